// File: rtl/alu_control_seq.sv
// Registered ALU control decoder between decode and execute: valid/ready handshake,
// multi-cycle MUL sequencing, synchronous flush and illegal-instruction flagging.
module alu_control_seq #(
  parameter int unsigned ALUCTRL_W  = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Function,
  input  logic [4:0]           Rt,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic                 Busy
);

  localparam int unsigned CNT_W    = $clog2(MUL_CYCLES) + 1;
  localparam int unsigned MUL_INIT = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  localparam logic [3:0] C_AND = 4'd0;
  localparam logic [3:0] C_OR  = 4'd1;
  localparam logic [3:0] C_ADD = 4'd2;
  localparam logic [3:0] C_XOR = 4'd3;
  localparam logic [3:0] C_NOR = 4'd4;
  localparam logic [3:0] C_SLL = 4'd5;
  localparam logic [3:0] C_SUB = 4'd6;
  localparam logic [3:0] C_SLT = 4'd7;
  localparam logic [3:0] C_SRL = 4'd8;
  localparam logic [3:0] C_MUL = 4'd9;
  localparam logic [3:0] C_GEZ = 4'd10;
  localparam logic [3:0] C_LTZ = 4'd11;
  localparam logic [3:0] C_GTZ = 4'd12;
  localparam logic [3:0] C_LEZ = 4'd13;
  localparam logic [3:0] C_ILL = 4'd15;

  typedef enum logic [1:0] {IDLE, HOLD, MULWAIT} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ALUCTRL_W-1:0] ctrl_q, ctrl_d;
  logic                 illegal_q, illegal_d;
  logic                 accept;
  logic [3:0]           dec_code;
  logic                 dec_mul;

  // Instruction fields to 4-bit ALU code; C_ILL marks an undecodable instruction.
  function automatic logic [3:0] decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rt);
    logic [3:0] c;
    c = C_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b000000: c = C_SLL;
          6'b000010: c = C_SRL;
          6'b100000: c = C_ADD;
          6'b100010: c = C_SUB;
          6'b100100: c = C_AND;
          6'b100101: c = C_OR;
          6'b100110: c = C_XOR;
          6'b100111: c = C_NOR;
          6'b101010: c = C_SLT;
          default:   c = C_ILL;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011, 6'b100000,
      6'b100001, 6'b101000, 6'b101001: c = C_ADD;
      6'b001100: c = C_AND;
      6'b001101: c = C_OR;
      6'b001110: c = C_XOR;
      6'b001010: c = C_SLT;
      6'b000100, 6'b000101: c = C_SUB;
      6'b000111: c = C_GTZ;
      6'b000110: c = C_LEZ;
      6'b011100: c = C_MUL;
      6'b000001: begin
        if (rt == 5'b00001)      c = C_GEZ;
        else if (rt == 5'b00000) c = C_LTZ;
        else                     c = C_ILL;
      end
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign dec_code = decode(OpCode, Function, Rt);
  assign dec_mul  = (OpCode == 6'b011100);
  assign InReady  = ~Flush & ((state_q == IDLE) | ((state_q == HOLD) & OutReady));
  assign accept   = InValid & InReady;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            illegal_d = (dec_code == C_ILL);
            ctrl_d    = (dec_code == C_ILL) ? '1 : ALUCTRL_W'(dec_code);
            if (dec_mul && (MUL_CYCLES > 1)) begin
              state_d = MULWAIT;
              cnt_d   = CNT_W'(MUL_INIT);
            end else begin
              state_d = HOLD;
            end
          end else if ((state_q == HOLD) && OutReady) begin
            state_d = IDLE;
          end
        end
        MULWAIT: begin
          if (cnt_q == '0) state_d = HOLD;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign OutValid   = (state_q == HOLD);
  assign Busy       = (state_q == MULWAIT);
  assign ALUControl = ctrl_q;
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomised and directed bench for alu_control_seq; two instances (MUL_CYCLES 4 and 1)
// are checked against a latency-counting transaction model.
module tb_alu_control_seq;

  localparam int unsigned W   = 4;
  localparam int          MC0 = 4;
  localparam int          MC1 = 1;
  localparam int          ILL = 15;

  logic Clk = 1'b0;
  logic Reset, Flush, InValid, OutReady;
  logic [5:0] OpCode, Function;
  logic [4:0] Rt;
  logic [1:0] in_ready, out_valid, illegal, busy;
  logic [1:0][W-1:0] alu_ctrl;

  always #5 Clk = ~Clk;

  alu_control_seq #(.ALUCTRL_W(W), .MUL_CYCLES(MC0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(in_ready[0]),
    .OpCode(OpCode), .Function(Function), .Rt(Rt), .OutValid(out_valid[0]),
    .OutReady(OutReady), .ALUControl(alu_ctrl[0]), .Illegal(illegal[0]), .Busy(busy[0]));

  alu_control_seq #(.ALUCTRL_W(W), .MUL_CYCLES(MC1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(in_ready[1]),
    .OpCode(OpCode), .Function(Function), .Rt(Rt), .OutValid(out_valid[1]),
    .OutReady(OutReady), .ALUControl(alu_ctrl[1]), .Illegal(illegal[1]), .Busy(busy[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining edges until the result appears, plus the visible result.
  int           pend  [2];
  bit           mv    [2];
  logic [W-1:0] mctrl [2];
  bit           mill  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt, output int code, output bit is_mul);
    is_mul = 1'b0;
    code   = ILL;
    if (op == 6'b000000) begin
      case (fn)
        6'b000000: code = 5;
        6'b000010: code = 8;
        6'b100000: code = 2;
        6'b100010: code = 6;
        6'b100100: code = 0;
        6'b100101: code = 1;
        6'b100110: code = 3;
        6'b100111: code = 4;
        6'b101010: code = 7;
        default:   code = ILL;
      endcase
    end else if (op inside {6'b001000, 6'b100011, 6'b101011, 6'b100000,
                            6'b100001, 6'b101000, 6'b101001}) code = 2;
    else if (op == 6'b001100) code = 0;
    else if (op == 6'b001101) code = 1;
    else if (op == 6'b001110) code = 3;
    else if (op == 6'b001010) code = 7;
    else if (op == 6'b000100 || op == 6'b000101) code = 6;
    else if (op == 6'b000111) code = 12;
    else if (op == 6'b000110) code = 13;
    else if (op == 6'b011100) begin code = 9; is_mul = 1'b1; end
    else if (op == 6'b000001) code = (rt == 5'd1) ? 10 : (rt == 5'd0) ? 11 : ILL;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; mv[i] = 1'b0; mctrl[i] = '0; mill[i] = 1'b0;
    end
  endtask

  // Called at a negedge: drive, check the current cycle, advance one edge, update model.
  task automatic tick(input bit iv, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rt, input bit ordy, input bit fl);
    bit acc [2];
    bit exp_rdy;
    int code, lat;
    bit is_mul;
    InValid = iv; OpCode = op; Function = fn; Rt = rt; OutReady = ordy; Flush = fl;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy = !fl && (pend[i] == 0) && (!mv[i] || ordy);
      check_eq($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(exp_rdy));
      check_eq($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mv[i]));
      check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(pend[i] > 0));
      if (mv[i]) begin
        check_eq($sformatf("alu_ctrl%0d", i), 32'(alu_ctrl[i]), 32'(mctrl[i]));
        check_eq($sformatf("illegal%0d", i), 32'(illegal[i]), 32'(mill[i]));
      end
      acc[i] = iv && exp_rdy;
    end
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (fl) begin
        pend[i] = 0; mv[i] = 1'b0;
      end else if (acc[i]) begin
        ref_decode(op, fn, rt, code, is_mul);
        mill[i]  = (code == ILL);
        mctrl[i] = (code == ILL) ? '1 : W'(code);
        lat = is_mul ? ((i == 0) ? MC0 : MC1) : 1;
        mv[i]   = (lat == 1);
        pend[i] = lat - 1;
      end else if (pend[i] > 0) begin
        pend[i]--;
        if (pend[i] == 0) mv[i] = 1'b1;
      end else if (mv[i] && ordy) begin
        mv[i] = 1'b0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0);
  endtask

  logic [5:0] st_op [0:18];
  logic [5:0] st_fn [0:18];
  logic [5:0] op_pool [0:19];
  logic [5:0] fn_pool [0:9];

  initial begin
    logic [5:0] op, fn;
    st_op = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
              6'b000000, 6'b001100, 6'b001000, 6'b100011, 6'b101011, 6'b101000, 6'b100001,
              6'b100000, 6'b101001, 6'b001101, 6'b001110, 6'b001010};
    st_fn = '{6'b000000, 6'b000010, 6'b101010, 6'b100101, 6'b100111, 6'b100110, 6'b100010,
              6'b100100, 6'b111111, 6'b010101, 6'b000000, 6'b100000, 6'b000010, 6'b101010,
              6'b110011, 6'b000001, 6'b100111, 6'b001100, 6'b011011};
    op_pool = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b100000, 6'b100001, 6'b101000,
                6'b101001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b000100, 6'b000101,
                6'b000111, 6'b000110, 6'b011100, 6'b000001, 6'b111111, 6'b010000};
    fn_pool = '{6'b000000, 6'b000010, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b101010, 6'b000001};

    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    OpCode = '0; Function = '0; Rt = '0;
    model_reset();
    @(negedge Clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_alu_ctrl", 32'(alu_ctrl), 32'(0));
    check_eq("rst_illegal", 32'(illegal), 32'(0));
    @(negedge Clk);
    Reset = 1'b0;

    // Reset in the middle of a MUL
    tick(1'b1, 6'b011100, 6'd0, 5'd0, 1'b1, 1'b0);
    idle(1);
    #2 Reset = 1'b1;
    #1;
    check_eq("rst_mid_busy", 32'(busy[0]), 32'(0));
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_mid_alu_ctrl", 32'(alu_ctrl), 32'(0));
    check_eq("rst_mid_illegal", 32'(illegal), 32'(0));
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    tick(1'b1, 6'b000000, 6'b100000, 5'd0, 1'b1, 1'b0);
    check_eq("t1_add_code", 32'(alu_ctrl[0]), 32'(4'b0010));
    check_eq("t1_add_valid", 32'(out_valid[0]), 32'(1));
    idle(2);

    // Back-to-back stream
    for (int k = 0; k < 19; k++) tick(1'b1, st_op[k], st_fn[k], 5'(k), 1'b1, 1'b0);
    idle(2);

    // MUL with other ops offered while busy
    tick(1'b1, 6'b011100, 6'b101010, 5'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 6'b001101, 6'd0, 5'd0, 1'b1, 1'b0);
    idle(4);

    // Backpressure on BEQ, then release with a new op loading that cycle
    tick(1'b1, 6'b000100, 6'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b1, 6'b000000, 6'b100000, 5'd0, 1'b0, 1'b0);
    check_eq("bp_beq_code", 32'(alu_ctrl[0]), 32'(4'b0110));
    tick(1'b1, 6'b001100, 6'd0, 5'd0, 1'b1, 1'b0);
    check_eq("bp_release_and", 32'(alu_ctrl[0]), 32'(4'b0000));
    idle(2);

    // Flush during MULWAIT and during HOLD
    tick(1'b1, 6'b011100, 6'd0, 5'd0, 1'b1, 1'b0);
    idle(1);
    tick(1'b1, 6'b000000, 6'b100000, 5'd0, 1'b1, 1'b1);
    idle(4);
    tick(1'b1, 6'b000000, 6'b100110, 5'd0, 1'b0, 1'b0);
    tick(1'b1, 6'b000000, 6'b100000, 5'd0, 1'b0, 1'b1);
    check_eq("flush_hold_keep", 32'(alu_ctrl[0]), 32'(4'b0011));
    idle(2);

    // REGIMM, illegal opcode, BGTZ, BLEZ, illegal R-type function
    tick(1'b1, 6'b000001, 6'd0, 5'b00001, 1'b1, 1'b0);
    check_eq("regimm_gez", 32'(alu_ctrl[0]), 32'(4'b1010));
    tick(1'b1, 6'b000001, 6'd0, 5'b00000, 1'b1, 1'b0);
    check_eq("regimm_ltz", 32'(alu_ctrl[0]), 32'(4'b1011));
    tick(1'b1, 6'b000001, 6'd0, 5'b00010, 1'b1, 1'b0);
    check_eq("regimm_bad", 32'(alu_ctrl[0]), 32'(4'b1111));
    check_eq("regimm_bad_ill", 32'(illegal[0]), 32'(1));
    tick(1'b1, 6'b111111, 6'd0, 5'd0, 1'b1, 1'b0);
    check_eq("op_ill", 32'(illegal[0]), 32'(1));
    tick(1'b1, 6'b000111, 6'd0, 5'd0, 1'b1, 1'b0);
    check_eq("bgtz", 32'(alu_ctrl[0]), 32'(4'b1100));
    tick(1'b1, 6'b000110, 6'd0, 5'd0, 1'b1, 1'b0);
    check_eq("blez", 32'(alu_ctrl[0]), 32'(4'b1101));
    tick(1'b1, 6'b000000, 6'b111000, 5'd0, 1'b1, 1'b0);
    idle(2);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      op = ($urandom_range(0, 9) < 3) ? 6'($urandom) : op_pool[$urandom_range(0, 19)];
      fn = ($urandom_range(0, 9) < 8) ? fn_pool[$urandom_range(0, 9)] : 6'($urandom);
      tick(1'($urandom_range(0, 3) != 0), op, fn, 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
